// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and decode helper for the E-stage multiply/divide unit.
// Codes 7-10 are only decoded when the accumulate feature is built in.
package muldiv_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd7;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd8;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd9;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DIV_FIX = 2'd3
  } state_t;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider core: go latches magnitudes and signs, WIDTH iterations at 1 bit/cycle,
// then done is high for one cycle with sign-corrected quotient/remainder; abort drops the op.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;

  always_comb begin
    w_dvd_neg = sgn & dividend[WIDTH-1];
    w_dvs_neg = sgn & divisor[WIDTH-1];
    w_dvd_abs = w_dvd_neg ? -dividend : dividend;
    w_dvs_abs = w_dvs_neg ? -divisor : divisor;
    // r_quo doubles as the dividend shift register: its MSB feeds the partial remainder.
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_qbit    = ~w_diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (abort) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (go) begin
      r_quo   <= w_dvd_abs;
      r_rem   <= '0;
      r_dvs   <= w_dvs_abs;
      r_cnt   <= CNT_W'(WIDTH);
      r_run   <= 1'b1;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end else if (r_run) begin
      if (r_cnt != '0) begin
        r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  always_comb begin
    done      = r_run && (r_cnt == '0);
    quotient  = r_neg_q ? -r_quo : r_quo;
    remainder = r_neg_r ? -r_rem : r_rem;
  end

endmodule

// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit owning HI/LO; MUL busy MUL_LAT cycles, DIV busy WIDTH+1, cancel only in first busy cycle.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built when MULDIV_MADD_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_first;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_dvz;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef MULDIV_MADD_EN
  logic               r_acc_en;
  logic               r_acc_sub;
`endif

  logic               w_accept;
  logic               w_abort;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_mul_sgn;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    w_mul_sgn = (op == OP_MULT);
`ifdef MULDIV_MADD_EN
    if ((op == OP_MADD) || (op == OP_MSUB)) begin
      w_is_mul  = 1'b1;
      w_mul_sgn = 1'b1;
    end
    if ((op == OP_MADDU) || (op == OP_MSUBU)) begin
      w_is_mul = 1'b1;
    end
`endif
    w_is_div = op_is_div(op);
    w_accept = start & ~cancel & ~busy;
    // The op's own instruction is still being flushed only in the cycle right after acceptance.
    w_abort  = r_first & cancel;
    // Sign/zero extension to 2*WIDTH makes a truncated product correct for both signednesses.
    w_ext_a  = {{WIDTH{w_mul_sgn & a[WIDTH-1]}}, a};
    w_ext_b  = {{WIDTH{w_mul_sgn & b[WIDTH-1]}}, b};
    w_prod   = w_ext_a * w_ext_b;
  end

  muldiv_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (w_accept && w_is_div),
    .abort    (w_abort && (r_state == ST_DIV_RUN)),
    .sgn      (op == OP_DIV),
    .dividend (a),
    .divisor  (b),
    .done     (w_div_done),
    .quotient (w_quo),
    .remainder(w_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_nxt = ST_MUL;
        end else if (w_accept && w_is_div) begin
          w_state_nxt = ST_DIV_RUN;
        end
      end
      ST_MUL: begin
        if (w_abort || (r_cnt == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DIV_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_DIV_FIX;
        end
      end
      ST_DIV_FIX: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_first   <= 1'b0;
      r_prod    <= '0;
      r_dvz     <= 1'b0;
      r_ovf     <= 1'b0;
      r_a       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MULDIV_MADD_EN
      r_acc_en  <= 1'b0;
      r_acc_sub <= 1'b0;
`endif
    end else begin
      r_first <= w_accept && (w_is_mul || w_is_div);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (op == OP_MTHI) r_hi <= a;
            if (op == OP_MTLO) r_lo <= a;
            if (w_is_mul) begin
              r_prod <= w_prod;
              r_cnt  <= CNT_W'(MUL_LAT - 1);
            end
            if (w_is_div) begin
              r_cnt <= CNT_W'(WIDTH - 1);
              r_dvz <= (b == '0);
              r_ovf <= (op == OP_DIV) && (a == MOST_NEG) && (&b);
              r_a   <= a;
            end
`ifdef MULDIV_MADD_EN
            r_acc_en  <= op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
            r_acc_sub <= (op == OP_MSUB) || (op == OP_MSUBU);
`endif
          end
        end
        ST_MUL: begin
          if (w_abort) begin
            r_cnt <= '0;
          end else if (r_cnt == '0) begin
`ifdef MULDIV_MADD_EN
            // Accumulator is read at completion so back-to-back MADDs chain correctly.
            if (r_acc_en) begin
              {r_hi, r_lo} <= r_acc_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);
            end else begin
              {r_hi, r_lo} <= r_prod;
            end
`else
            {r_hi, r_lo} <= r_prod;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DIV_RUN: begin
          if (w_abort) begin
            r_cnt <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DIV_FIX: begin
          if (w_div_done) begin
            if (r_dvz) begin
              r_lo <= '1;
              r_hi <= r_a;
            end else if (r_ovf) begin
              r_lo <= r_a;
              r_hi <= '0;
            end else begin
              r_lo <= w_quo;
              r_hi <= w_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
